// File: rtl/bram_dual_port_pkg.sv
// Shared types and widths for the dual-port block RAM.
package bram_dual_port_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef enum logic {
    RW_READ  = 1'b0,
    RW_WRITE = 1'b1
  } rw_e;

endpackage

// File: rtl/bram_dual_port_side.sv
// One RAM port: word-index computation, write enable, and the registered
// ready/rdata handshake outputs.
module bram_dual_port_side
  import bram_dual_port_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SIZE     = 1024,
  parameter int unsigned ADDR_LSH = 2,
  localparam int unsigned IDX_W   = $clog2(SIZE)
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              request,
  input  logic              rw,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [IDX_W-1:0]  index_c,
  output logic              we_c,
  output logic [WIDTH-1:0]  rdata,
  output logic              ready
);

  // Byte address to word index; out-of-range addresses wrap rather than fault.
  function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
    return IDX_W'((addr >> ADDR_LSH) % ADDR_W'(SIZE));
  endfunction

  always_comb begin
    index_c = word_index(address);
    we_c    = i_reset_n && request && (rw_e'(rw) == RW_WRITE);
  end

  // mem_rdata is the pre-write word, so both reads and writes are read-first.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      ready <= 1'b0;
      rdata <= '0;
    end else if (request) begin
      ready <= 1'b1;
      rdata <= mem_rdata;
    end else begin
      ready <= 1'b0;
    end
  end

endmodule

// File: rtl/bram_dual_port.sv
// True dual-port synchronous RAM: two independent request/ready ports over
// one storage array, one-cycle registered read data.
module bram_dual_port
  import bram_dual_port_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SIZE     = 1024,
  parameter int unsigned ADDR_LSH = 2
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_pa_request,
  input  logic              i_pa_rw,
  input  logic [ADDR_W-1:0] i_pa_address,
  input  logic [WIDTH-1:0]  i_pa_wdata,
  output logic [WIDTH-1:0]  o_pa_rdata,
  output logic              o_pa_ready,
  input  logic              i_pb_request,
  input  logic              i_pb_rw,
  input  logic [ADDR_W-1:0] i_pb_address,
  input  logic [WIDTH-1:0]  i_pb_wdata,
  output logic [WIDTH-1:0]  o_pb_rdata,
  output logic              o_pb_ready
);

  localparam int unsigned IDX_W = $clog2(SIZE);

  // Contents start at zero and are deliberately untouched by reset.
  logic [WIDTH-1:0] mem [SIZE] = '{default: '0};

  logic [IDX_W-1:0] a_index_c;
  logic [IDX_W-1:0] b_index_c;
  logic             a_we_c;
  logic             b_we_c;
  logic [WIDTH-1:0] a_mem_rdata_c;
  logic [WIDTH-1:0] b_mem_rdata_c;

  always_comb begin
    a_mem_rdata_c = mem[a_index_c];
    b_mem_rdata_c = mem[b_index_c];
  end

  bram_dual_port_side #(
    .WIDTH    (WIDTH),
    .SIZE     (SIZE),
    .ADDR_LSH (ADDR_LSH)
  ) u_side_a (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .request   (i_pa_request),
    .rw        (i_pa_rw),
    .address   (i_pa_address),
    .mem_rdata (a_mem_rdata_c),
    .index_c   (a_index_c),
    .we_c      (a_we_c),
    .rdata     (o_pa_rdata),
    .ready     (o_pa_ready)
  );

  bram_dual_port_side #(
    .WIDTH    (WIDTH),
    .SIZE     (SIZE),
    .ADDR_LSH (ADDR_LSH)
  ) u_side_b (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .request   (i_pb_request),
    .rw        (i_pb_rw),
    .address   (i_pb_address),
    .mem_rdata (b_mem_rdata_c),
    .index_c   (b_index_c),
    .we_c      (b_we_c),
    .rdata     (o_pb_rdata),
    .ready     (o_pb_ready)
  );

  // Port B is written last so it wins a same-index write collision.
  always_ff @(posedge i_clock) begin
    if (a_we_c) mem[a_index_c] <= i_pa_wdata;
    if (b_we_c) mem[b_index_c] <= i_pb_wdata;
  end

endmodule

// File: tb/tb_bram_dual_port.sv
// Randomized and directed bench for bram_dual_port against an array-based
// reference model of the two-port read-first RAM.
module tb_bram_dual_port;

  localparam int unsigned WIDTH    = 24;
  localparam int unsigned SIZE     = 200;
  localparam int unsigned ADDR_LSH = 2;

  logic              i_clock = 1'b0;
  logic              i_reset_n;
  logic              i_pa_request, i_pa_rw;
  logic [31:0]       i_pa_address;
  logic [WIDTH-1:0]  i_pa_wdata;
  logic [WIDTH-1:0]  o_pa_rdata;
  logic              o_pa_ready;
  logic              i_pb_request, i_pb_rw;
  logic [31:0]       i_pb_address;
  logic [WIDTH-1:0]  i_pb_wdata;
  logic [WIDTH-1:0]  o_pb_rdata;
  logic              o_pb_ready;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] model [SIZE];
  logic [WIDTH-1:0] exp_a_rdata, exp_b_rdata;
  logic             exp_a_ready, exp_b_ready;

  always #5 i_clock = ~i_clock;

  bram_dual_port #(
    .WIDTH    (WIDTH),
    .SIZE     (SIZE),
    .ADDR_LSH (ADDR_LSH)
  ) dut (
    .i_clock      (i_clock),
    .i_reset_n    (i_reset_n),
    .i_pa_request (i_pa_request),
    .i_pa_rw      (i_pa_rw),
    .i_pa_address (i_pa_address),
    .i_pa_wdata   (i_pa_wdata),
    .o_pa_rdata   (o_pa_rdata),
    .o_pa_ready   (o_pa_ready),
    .i_pb_request (i_pb_request),
    .i_pb_rw      (i_pb_rw),
    .i_pb_address (i_pb_address),
    .i_pb_wdata   (i_pb_wdata),
    .o_pb_rdata   (o_pb_rdata),
    .o_pb_ready   (o_pb_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int word_idx(input logic [31:0] addr);
    return int'((addr >> ADDR_LSH) % SIZE);
  endfunction

  // Apply one cycle of stimulus (called just after a falling edge), update the
  // model as the RAM should, then compare all outputs after the rising edge.
  task automatic step(input logic rst_n,
                      input logic ra, input logic wa, input logic [31:0] aa, input logic [WIDTH-1:0] da,
                      input logic rb, input logic wb, input logic [31:0] ab, input logic [WIDTH-1:0] db);
    int ia, ib;
    i_reset_n    = rst_n;
    i_pa_request = ra; i_pa_rw = wa; i_pa_address = aa; i_pa_wdata = da;
    i_pb_request = rb; i_pb_rw = wb; i_pb_address = ab; i_pb_wdata = db;
    ia = word_idx(aa);
    ib = word_idx(ab);
    if (!rst_n) begin
      exp_a_ready = 1'b0; exp_a_rdata = '0;
      exp_b_ready = 1'b0; exp_b_rdata = '0;
    end else begin
      exp_a_ready = ra;
      exp_b_ready = rb;
      if (ra) exp_a_rdata = model[ia];
      if (rb) exp_b_rdata = model[ib];
      if (ra && wa) model[ia] = da;
      if (rb && wb) model[ib] = db;
    end
    @(posedge i_clock);
    @(negedge i_clock);
    check("pa_ready", 32'(o_pa_ready), 32'(exp_a_ready));
    check("pb_ready", 32'(o_pb_ready), 32'(exp_b_ready));
    check("pa_rdata", 32'(o_pa_rdata), 32'(exp_a_rdata));
    check("pb_rdata", 32'(o_pb_rdata), 32'(exp_b_rdata));
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 32'd0, '0, 1'b0, 1'b0, 32'd0, '0);
  endtask

  initial begin
    for (int i = 0; i < int'(SIZE); i++) model[i] = '0;
    exp_a_rdata = '0; exp_b_rdata = '0;
    exp_a_ready = 1'b0; exp_b_ready = 1'b0;
    i_reset_n = 1'b0;
    i_pa_request = 1'b0; i_pa_rw = 1'b0; i_pa_address = '0; i_pa_wdata = '0;
    i_pb_request = 1'b0; i_pb_rw = 1'b0; i_pb_address = '0; i_pb_wdata = '0;
    @(negedge i_clock);

    // Reset with write requests pending: nothing may be stored.
    repeat (3) step(1'b0, 1'b1, 1'b1, 32'h08, 24'h555555, 1'b1, 1'b1, 32'h0C, 24'h666666);
    check("rst_ready", 32'(o_pa_ready), 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h08, '0, 1'b1, 1'b0, 32'h0C, '0);
    check("rst_nowrite_a", 32'(o_pa_rdata), 32'd0);
    check("rst_nowrite_b", 32'(o_pb_rdata), 32'd0);

    // Write on A, read back on B.
    step(1'b1, 1'b1, 1'b1, 32'h08, 24'hABCDEF, 1'b0, 1'b0, 32'd0, '0);
    check("wr_ready", 32'(o_pa_ready), 32'd1);
    step(1'b1, 1'b0, 1'b0, 32'd0, '0, 1'b1, 1'b0, 32'h08, '0);
    check("wr_rd_data", 32'(o_pb_rdata), 32'hABCDEF);

    // Streaming read with address changing every cycle.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b1, 32'(4 * i), WIDTH'(i + 1), 1'b0, 1'b0, 32'd0, '0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'd0, '0, 1'b1, 1'b0, 32'(4 * i), '0);
      check("stream_data", 32'(o_pb_rdata), 32'(i + 1));
      check("stream_ready", 32'(o_pb_ready), 32'd1);
    end

    // Same-index writes: B wins. Write vs read: reader sees old data.
    step(1'b1, 1'b1, 1'b1, 32'd20, 24'h11, 1'b1, 1'b1, 32'd20, 24'h22);
    step(1'b1, 1'b1, 1'b0, 32'd20, '0, 1'b0, 1'b0, 32'd0, '0);
    check("coll_ww", 32'(o_pa_rdata), 32'h22);
    step(1'b1, 1'b1, 1'b1, 32'd24, 24'h33, 1'b1, 1'b0, 32'd24, '0);
    check("coll_wr_old", 32'(o_pb_rdata), 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'd0, '0, 1'b1, 1'b0, 32'd24, '0);
    check("coll_wr_new", 32'(o_pb_rdata), 32'h33);

    // Address beyond SIZE words (with stray low bits) aliases index 9.
    step(1'b1, 1'b1, 1'b1, 32'(SIZE * 4 + 36 + 3), 24'h7, 1'b0, 1'b0, 32'd0, '0);
    step(1'b1, 1'b0, 1'b0, 32'd0, '0, 1'b1, 1'b0, 32'd36, '0);
    check("wrap", 32'(o_pb_rdata), 32'h7);

    // Reset while A is writing: write dropped, earlier data kept.
    step(1'b1, 1'b1, 1'b1, 32'd40, 24'h44, 1'b0, 1'b0, 32'd0, '0);
    step(1'b0, 1'b1, 1'b1, 32'd36, 24'h99, 1'b0, 1'b0, 32'd0, '0);
    check("midrst_ready", 32'(o_pa_ready), 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd36, '0, 1'b1, 1'b0, 32'd40, '0);
    check("midrst_keep", 32'(o_pa_rdata), 32'h7);
    check("midrst_prev", 32'(o_pb_rdata), 32'h44);

    // Random traffic, biased toward a few indices to provoke collisions.
    for (int n = 0; n < 800; n++) begin
      logic [31:0] aa, ab;
      aa = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom_range(0, SIZE * 8));
      ab = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom_range(0, SIZE * 8));
      step(($urandom_range(0, 39) != 0),
           1'($urandom), 1'($urandom), aa, WIDTH'($urandom),
           1'($urandom), 1'($urandom), ab, WIDTH'($urandom));
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
